// File: rtl/mxv_pkg.sv
// Shared types for the matrix-vector result path: collector FSM states and the
// row-tagged FIFO entry layout at the default result width.
package mxv_pkg;

    localparam int SizeDefault = 8;
    localparam int RowsDefault = 8;
    localparam int RwDefault   = $clog2(RowsDefault);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [RwDefault-1:0]   row;
        logic [SizeDefault-1:0] data;
    } entry_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO with registered storage; the head word is read straight
// from the storage array so nothing on the write side reaches rdata combinationally.
module result_fifo #(
    parameter int Width = 11,
    parameter int Depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] FullCount = (AW+1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FullCount);
    assign empty = (count == '0);

endmodule

// File: rtl/result_collector.sv
// Collects one selector result per matrix row into a row-tagged FIFO, presents
// them over valid/ready, and pulses matrix_done once every row has drained.
module result_collector
    import mxv_pkg::*;
#(
    parameter int Size  = SizeDefault,
    parameter int Depth = 4,
    parameter int Rows  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     send,
    input  logic [Size-1:0]          result_send,
    output logic [Size-1:0]          out_data,
    output logic [$clog2(Rows)-1:0]  out_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     matrix_done,
    output logic                     overflow
);

    localparam int RW = $clog2(Rows);
    localparam int CW = $clog2(Depth) + 1;
    localparam logic [RW-1:0] LastRow = RW'(Rows - 1);

    state_t          state;
    logic [RW-1:0]   row_cnt;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            pop;
    logic            attempt;
    logic            accept;
    logic            drain_empty;

    assign pop     = out_valid && out_ready;
    assign attempt = (state == COLLECT) && send;
    // A full FIFO still takes the word when the consumer frees a slot this cycle.
    assign accept  = attempt && (!fifo_full || pop);
    assign drain_empty = fifo_empty || ((fifo_count == CW'(1)) && pop);

    result_fifo #(
        .Width (Size + RW),
        .Depth (Depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .wdata ({row_cnt, result_send}),
        .rdata ({out_row, out_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            row_cnt     <= '0;
            overflow    <= 1'b0;
            matrix_done <= 1'b0;
        end else begin
            matrix_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        row_cnt  <= '0;
                        overflow <= 1'b0;
                    end
                end
                // Dropped words still consume a row slot so row tags stay aligned.
                COLLECT: begin
                    if (send) begin
                        if (!accept) begin
                            overflow <= 1'b1;
                        end
                        if (row_cnt == LastRow) begin
                            row_cnt <= '0;
                            state   <= DRAIN;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        matrix_done <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = !fifo_empty;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: stimulus queues expected row/data pairs,
// a negedge monitor pops them whenever the DUT hands a word to the consumer.
module tb_result_collector;
    import mxv_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       send;
    logic [7:0] result_send;
    logic [7:0] out_data;
    logic [2:0] out_row;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       matrix_done;
    logic       overflow;

    entry_t exp_q[$];
    entry_t mon_e;
    int     checks = 0;
    int     passed = 0;
    int     done_cnt = 0;

    result_collector #(
        .Size  (8),
        .Depth (4),
        .Rows  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .send        (send),
        .result_send (result_send),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .matrix_done (matrix_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (reset && matrix_done) begin
            done_cnt++;
        end
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_output: got row %0d data %0h, expected none",
                         out_row, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("out_row", int'(out_row), int'(mon_e.row));
                check_output("out_data", int'(out_data), int'(mon_e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic ready,
                                  input bit expect_push, input logic [2:0] row);
        entry_t e;
        send        = 1'b1;
        result_send = data;
        out_ready   = ready;
        if (expect_push) begin
            e.row  = row;
            e.data = data;
            exp_q.push_back(e);
        end
        step();
        send = 1'b0;
    endtask

    task automatic start_matrix();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int expected);
        int n;
        n = 0;
        while (done_cnt < expected && n < 50) begin
            step();
            n++;
        end
        repeat (2) step();
        check_output("matrix_done_pulses", done_cnt, expected);
        check_output("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset held with active inputs
        reset       = 1'b0;
        start       = 1'b1;
        send        = 1'b1;
        out_ready   = 1'b0;
        result_send = 8'hFF;
        repeat (3) step();
        check_output("rst_out_valid", int'(out_valid), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_matrix_done", int'(matrix_done), 0);
        check_output("rst_overflow", int'(overflow), 0);
        check_output("rst_out_data", int'(out_data), 0);
        start = 1'b0;
        send  = 1'b0;
        reset = 1'b1;
        step();
        check_output("idle_busy", int'(busy), 0);

        // Basic collect with the consumer always ready
        out_ready = 1'b1;
        start_matrix();
        check_output("collect_busy", int'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(8'(8'h10 + i), 1'b1, 1'b1, 3'(i));
            check_output("lat_valid", int'(out_valid), 1);
            check_output("lat_data", int'(out_data), 16 + i);
            check_output("lat_row", int'(out_row), i);
        end
        wait_done(1);

        // Backpressure then overflow, then drain
        out_ready = 1'b0;
        start_matrix();
        check_output("bp_overflow_clear", int'(overflow), 0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(8'(8'hA0 + i), 1'b0, (i < 4), 3'(i));
        end
        check_output("bp_overflow_set", int'(overflow), 1);
        check_output("bp_head_data", int'(out_data), 'hA0);
        check_output("bp_head_row", int'(out_row), 0);
        for (int i = 5; i < 8; i++) begin
            apply_stimulus(8'(8'hA0 + i), 1'b1, 1'b1, 3'(i));
        end
        wait_done(2);
        check_output("bp_overflow_sticky", int'(overflow), 1);

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        start_matrix();
        check_output("restart_overflow_clear", int'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(8'(8'hB0 + i), 1'b0, 1'b1, 3'(i));
        end
        apply_stimulus(8'hB4, 1'b1, 1'b1, 3'd4);
        check_output("full_pp_overflow", int'(overflow), 0);
        check_output("full_pp_head", int'(out_data), 'hB1);
        for (int i = 5; i < 8; i++) begin
            apply_stimulus(8'(8'hB0 + i), 1'b1, 1'b1, 3'(i));
        end
        wait_done(3);
        check_output("full_pp_no_overflow", int'(overflow), 0);

        // Ignored send in IDLE, ignored start in COLLECT
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(8'hEE, 1'b0, 1'b0, 3'd0);
        end
        check_output("idle_send_valid", int'(out_valid), 0);
        check_output("idle_send_busy", int'(busy), 0);
        out_ready = 1'b1;
        start_matrix();
        for (int i = 0; i < 8; i++) begin
            start = (i == 3);
            apply_stimulus(8'(8'hC0 + i), 1'b1, 1'b1, 3'(i));
            start = 1'b0;
        end
        wait_done(4);

        // Reset mid-matrix discards contents without a done pulse
        out_ready = 1'b0;
        start_matrix();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(8'(8'hD0 + i), 1'b0, 1'b0, 3'(i));
        end
        check_output("mid_valid_before", int'(out_valid), 1);
        reset = 1'b0;
        #2;
        check_output("mid_rst_valid", int'(out_valid), 0);
        check_output("mid_rst_busy", int'(busy), 0);
        step();
        reset = 1'b1;
        repeat (3) step();
        check_output("mid_rst_no_done", done_cnt, 4);
        out_ready = 1'b1;
        start_matrix();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(8'(8'hE0 + i), 1'b1, 1'b1, 3'(i));
        end
        wait_done(5);

        check_output("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name:
result_collector

Overview:
- Downstream stage of the 4-way result selector. It consumes the `send` strobe and the selected `result_send` word, one per completed matrix row.
- Each accepted result is tagged with its row index and buffered in a small FIFO.
- Results are presented to the output consumer through a valid/ready handshake.
- The block tracks matrix completion. It pulses `matrix_done` once all rows have been collected and drained.

Parameters:
- Size, 8, width of result words (matches the selector's Size).
- Depth, 4, number of FIFO entries; power of two, at least 2.
- Rows, 8, rows per matrix; at least 2. RW = $clog2(Rows).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begins collection of a new matrix; sampled only in IDLE.
- send  in  1  selector strobe; result_send is valid this cycle.
- result_send  in  Size  selected result word.
- out_data  out  Size  head-of-FIFO result.
- out_row  out  RW  row index of out_data.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word this cycle.
- busy  out  1  state is not IDLE.
- matrix_done  out  1  one-cycle pulse when a matrix has been fully drained.
- overflow  out  1  sticky flag: a result was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE; row_cnt=0; FIFO pointers and count are 0.
  - All outputs are 0.
  - Reset mid-operation discards FIFO contents.
- FSM states: IDLE, COLLECT, DRAIN.
  - IDLE: send is ignored (no push, no overflow). start=1 moves to COLLECT next cycle, clears row_cnt and clears overflow.
  - COLLECT: a cycle with send=1 is a push attempt using entry {row_cnt, result_send}. row_cnt increments on every push attempt, whether accepted or dropped. When an attempt occurs with row_cnt==Rows-1, move to DRAIN next cycle.
  - DRAIN: send is ignored. When the FIFO is empty (count==0, including after a pop this cycle makes it 0), matrix_done=1 for exactly one cycle, then return to IDLE.
  - start outside IDLE is ignored.
- Push acceptance: a push is accepted if count<Depth, or if count==Depth and a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set; overflow stays set until the next start or reset.
- Pop: occurs when out_valid and out_ready are both 1.
  - out_valid = (count!=0).
  - out_data and out_row come from the head storage register; no combinational path from send or result_send.
- Latency: a word accepted at edge N is visible on out_valid, out_data and out_row after edge N, i.e. 1 cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo Depth.
- Row_cnt wraps to 0 on the transition to DRAIN.
- busy=1 in COLLECT and DRAIN.
- matrix_done is registered and asserts in the cycle after the FIFO becomes empty in DRAIN.

Decomposition:
- Package mxv_pkg holds:
  - the state enum: IDLE, COLLECT, DRAIN;
  - the FIFO entry struct: row (RW bits) and data (Size bits);
  - the shared default Size constant.
- Sub-module result_fifo (parameters Size+RW and Depth) provides push, pop, full, empty, count and head data, with storage and pointers only.
- result_collector wraps result_fifo with the FSM, row counter and overflow logic.

Test Plan:
- Reset: hold reset=0 with send=1 and start=1 → out_valid, busy, matrix_done and overflow are all 0. Release reset → state is IDLE.
- Basic collect, with out_ready=1: pulse start, then 8 sends of values 0x10..0x17 on consecutive cycles → out_data is 0x10..0x17 with out_row 0..7, each 1 cycle after its send. matrix_done pulses once; busy then falls.
- Backpressure and overflow, with out_ready=0: start, then 5 sends of 0xA0..0xA4 → the FIFO holds 0xA0..0xA3 and overflow=1. Then out_ready=1 and 3 more sends of 0xA5..0xA7 → the output sequence is A0,A1,A2,A3,A5,A6,A7 with rows 0,1,2,3,5,6,7, followed by matrix_done.
- Full FIFO with simultaneous push and pop: fill 4 entries, then in one cycle assert send=1 and out_ready=1 → the word is accepted, overflow stays 0 and count stays 4.
- Ignored inputs: send in IDLE produces no out_valid; start during COLLECT does not reset row_cnt; a second start after matrix_done clears overflow and restarts out_row at 0.
- Reset mid-matrix: after 3 sends, pulse reset low → FIFO empties, state is IDLE, no matrix_done pulse. A new start with 8 sends completes normally.
